txtbuf_arbiter: RTL

Single-port controller for the 40x24 text buffer (960 bytes mapped at 16'h400). It shares one synchronous RAM port between the video display processor's character fetches and a CPU-side read/write port. It also owns the clear engine that fills the buffer with the blank glyph after reset or on request. It sits between `vdp` and the text RAM inside `framebuffer`.

---
 rtl/txtbuf_pkg.sv | 21 ++
 rtl/txtbuf_clear.sv | 39 +++
 rtl/txtbuf_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/txtbuf_pkg.sv
// Shared constants, state encoding and address helpers for the text-buffer arbiter.
package txtbuf_pkg;

   localparam logic [15:0] TXT_BASE  = 16'h0400;
   localparam int          TXT_DEPTH = 960;
   localparam logic [7:0]  TXT_FILL  = 8'hA0;
   localparam int          TXT_AW    = $clog2(TXT_DEPTH);

   typedef enum logic [1:0] {CLEAR, IDLE, CPU_WAIT} txtbuf_state_t;

   // Offset wraps at 16 bits, so addresses below the base land far out of range.
   function automatic logic [15:0] txt_offset(input logic [15:0] adr, input logic [15:0] base);
      return adr - base;
   endfunction

   function automatic logic txt_in_range(input logic [15:0] adr, input logic [15:0] base,
                                         input int depth);
      return txt_offset(adr, base) < 16'(depth);
   endfunction

endpackage

// File: rtl/txtbuf_clear.sv
// Clear engine: walks offsets 0..DEPTH-1 once per start; busy means "issue a write this cycle".
module txtbuf_clear
   import txtbuf_pkg::*;
#(
   parameter int DEPTH = TXT_DEPTH,
   parameter int AW    = TXT_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic [AW-1:0] addr,
   output logic          last
);

   logic [AW-1:0] cnt;
   logic          done;

   // A start (or restart) issues offset 0 on the same edge, so no idle gap before the sweep.
   assign busy = start || !done;
   assign addr = start ? '0 : cnt;
   assign last = busy && (addr == AW'(DEPTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (busy) begin
         if (last) begin
            cnt  <= '0;
            done <= 1'b1;
         end else begin
            cnt  <= addr + AW'(1);
            done <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/txtbuf_arbiter.sv
// Single-port text RAM arbiter: VDP fetches (strict priority), CPU read/write, and clear engine.
// Define TXTBUF_CLEAR_EN to build in the clear engine (fill on reset release and on clear_req).
module txtbuf_arbiter
   import txtbuf_pkg::*;
#(
   parameter logic [15:0] ADDR_BASE = TXT_BASE,
   parameter int          DEPTH     = TXT_DEPTH,
   parameter logic [7:0]  FILL      = TXT_FILL,
   parameter int          AW        = $clog2(DEPTH)
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          vdp_rd,
   input  logic [15:0]   vdp_adr,
   output logic          vdp_valid,
   output logic [7:0]    vdp_txt,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [15:0]   cpu_adr,
   input  logic [7:0]    cpu_wdata,
   output logic          cpu_ack,
   output logic [7:0]    cpu_rdata,
   input  logic          clear_req,
   output logic          busy,
   output logic [AW-1:0] mem_a,
   output logic          mem_we,
   output logic [7:0]    mem_d,
   input  logic [7:0]    mem_q,
   output txtbuf_state_t state
);

   logic [15:0]   vdp_off, cpu_off;
   logic          vdp_in, cpu_in;
   logic          clr_start, clr_issue, clr_last, cpu_grant;
   logic [AW-1:0] clr_addr;
   logic          vdp_pend, vdp_fill, rd_fill;
   logic          unused_bits;

   assign vdp_off = txt_offset(vdp_adr, ADDR_BASE);
   assign cpu_off = txt_offset(cpu_adr, ADDR_BASE);
   assign vdp_in  = txt_in_range(vdp_adr, ADDR_BASE, DEPTH);
   assign cpu_in  = txt_in_range(cpu_adr, ADDR_BASE, DEPTH);

`ifdef TXTBUF_CLEAR_EN
   localparam txtbuf_state_t RST_STATE = CLEAR;
   localparam logic          RST_BUSY  = 1'b1;
   logic clr_pend;

   // A clear requested while a CPU read is in flight waits until that read has been acked.
   assign clr_start = (clear_req && (state == IDLE || state == CLEAR)) ||
                      (clr_pend && state == IDLE);
   assign unused_bits = ^{vdp_off[15:AW], cpu_off[15:AW]};

   txtbuf_clear #(.DEPTH(DEPTH), .AW(AW)) u_clear (
      .clk   (CLOCK_50),
      .rst   (reset),
      .start (clr_start),
      .busy  (clr_issue),
      .addr  (clr_addr),
      .last  (clr_last)
   );

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)                               clr_pend <= 1'b0;
      else if (clr_start)                      clr_pend <= 1'b0;
      else if (clear_req && state == CPU_WAIT) clr_pend <= 1'b1;
   end
`else
   localparam txtbuf_state_t RST_STATE = IDLE;
   localparam logic          RST_BUSY  = 1'b0;

   assign clr_start   = 1'b0;
   assign clr_issue   = 1'b0;
   assign clr_last    = 1'b0;
   assign clr_addr    = '0;
   assign unused_bits = ^{vdp_off[15:AW], cpu_off[15:AW], clear_req};
`endif

   // cpu_ack high blocks the grant: the held request in the ack cycle belongs to the old transaction.
   assign cpu_grant = (state == IDLE) && cpu_req && !vdp_rd && !cpu_ack && !clr_start;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state     <= RST_STATE;
         busy      <= RST_BUSY;
         mem_a     <= '0;
         mem_we    <= 1'b0;
         mem_d     <= '0;
         vdp_pend  <= 1'b0;
         vdp_fill  <= 1'b0;
         vdp_valid <= 1'b0;
         vdp_txt   <= '0;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
         rd_fill   <= 1'b0;
      end else begin
         mem_we    <= 1'b0;
         cpu_ack   <= 1'b0;
         busy      <= clr_issue;
         vdp_pend  <= vdp_rd;
         vdp_fill  <= clr_issue || !vdp_in;
         vdp_valid <= vdp_pend;
         if (vdp_pend) vdp_txt <= vdp_fill ? FILL : mem_q;

         if (clr_issue) begin
            mem_a  <= clr_addr;
            mem_we <= 1'b1;
            mem_d  <= FILL;
            state  <= clr_last ? IDLE : CLEAR;
         end else if (vdp_rd) begin
            if (vdp_in) mem_a <= vdp_off[AW-1:0];
         end else if (cpu_grant) begin
            if (cpu_in) mem_a <= cpu_off[AW-1:0];
            if (cpu_we) begin
               mem_we  <= cpu_in;
               cpu_ack <= 1'b1;
               if (cpu_in) mem_d <= cpu_wdata;
            end else begin
               rd_fill <= !cpu_in;
               state   <= CPU_WAIT;
            end
         end

         if (state == CPU_WAIT) begin
            cpu_ack   <= 1'b1;
            cpu_rdata <= rd_fill ? FILL : mem_q;
            state     <= IDLE;
         end
      end
   end

endmodule
